// File: rtl/klingon_scan_driver.sv
// klingon_scan_driver
//   Time-multiplexed scanner for a common-anode 4-digit Klingon 7-segment
//   display. Stores four 4-bit glyph codes, shows them one at a time with a
//   dark gap between digits to stop ghosting, and drives active-low enables.
//
//   Optional build macro: KLINGON_LZ_BLANK_EN
//     defined   -> leading-zero suppression on digits 3..1 (digit 0 always lit)
//     undefined -> only the external blank mask darkens digits
//   Scan timing, code and frame_start are the same in both builds.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   SHOW  | current digit lit (unless blanked) for SCAN_DIV clocks
//   GAP   | all digits dark for GAP_CYC clocks, then advance to next digit

module klingon_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 2,
  parameter int CNT_W    = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_en,
  input  logic [1:0] i_wr_addr,
  input  logic [3:0] i_wr_data,
  input  logic [3:0] i_blank,
  output logic [3:0] o_code,
  output logic [3:0] o_an,
  output logic [1:0] o_digit_idx,
  output logic       o_frame_start
);

  typedef enum logic {
    ST_SHOW = 1'b0,
    ST_GAP  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [3:0]       r_digit [4];

  logic [3:0]       w_lz_ok;
  logic [3:0]       w_lit;
  logic [3:0]       w_onehot_n;

  // Glyph storage: a write lands on its own edge, independent of the scan.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < 4; k++) begin
        r_digit[k] <= 4'd0;
      end
    end else if (i_wr_en) begin
      r_digit[i_wr_addr] <= i_wr_data;
    end
  end

  // Scan FSM: dwell counter per state, digit index advances leaving GAP.
  // Reset parks in GAP at idx 3 so the first lit digit after release is 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_GAP;
      r_cnt   <= '0;
      r_idx   <= 2'd3;
    end else begin
      case (r_state)
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            r_state <= ST_GAP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= ST_SHOW;
            r_cnt   <= '0;
            r_idx   <= r_idx + 2'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_GAP;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef KLINGON_LZ_BLANK_EN
  // Digit k may light only if it or some higher digit is non-zero; digit 0 always may.
  always_comb begin
    w_lz_ok    = 4'b0001;
    w_lz_ok[3] = (r_digit[3] != 4'd0);
    w_lz_ok[2] = w_lz_ok[3] | (r_digit[2] != 4'd0);
    w_lz_ok[1] = w_lz_ok[2] | (r_digit[1] != 4'd0);
  end
`else
  // Without suppression every digit is eligible to light.
  always_comb begin
    w_lz_ok = 4'b1111;
  end
`endif

  // Output decode straight from registered state; blank mask is live.
  always_comb begin
    w_lit         = ~i_blank & w_lz_ok;
    w_onehot_n    = ~(4'b0001 << r_idx);
    o_an          = 4'b1111;
    if (r_state == ST_SHOW && w_lit[r_idx]) begin
      o_an = w_onehot_n;
    end
    o_code        = r_digit[r_idx];
    o_digit_idx   = r_idx;
    o_frame_start = (r_state == ST_SHOW) && (r_idx == 2'd0) && (r_cnt == '0);
  end

endmodule
